// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx receiver slice.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } uart_rx_state_t;

    typedef logic [7:0] byte_t;

    localparam int unsigned OVERSAMPLE = 16;

    // Even parity holds when the data bits plus the parity bit have an even count of ones.
    function automatic logic parity_ok(input byte_t d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO with synchronous write.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                   clk_50,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_50) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a FWFT byte FIFO with frame, overrun and parity error pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk_50,
    input  logic                   rst,
    input  logic                   rx,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int unsigned DIV       = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0]  TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

    logic             rx_meta_q;
    logic             rxs_q;
    uart_rx_state_t   state_q,      state_d;
    logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
    logic [3:0]       tick_cnt_q,   tick_cnt_d;
    logic [2:0]       bit_cnt_q,    bit_cnt_d;
    byte_t            shift_q,      shift_d;
    logic             frame_err_q,  frame_err_d;
    logic             overrun_q,    overrun_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q,    par_bit_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic             tick;
    logic             mid_sample;
    logic             bit_sample;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    assign tick       = (div_cnt_q == DIV_W'(DIV - 1));
    assign mid_sample = tick && (tick_cnt_q == TICK_MID);
    assign bit_sample = tick && (tick_cnt_q == TICK_LAST);
    assign pop        = rx_valid && rx_ready;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        tick_cnt_d  = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d    = START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (mid_sample) begin
                    if (!rxs_q) begin
                        // Realign so every later sample lands 16 ticks on, at mid-bit.
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        tick_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_sample) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_sample) begin
                    par_bit_d = rxs_q;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_sample) begin
                    if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
                        if (parity_ok(shift_q, par_bit_q)) begin
                            push = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_50 (clk_50),
        .rst    (rst),
        .push   (push),
        .din    (shift_q),
        .pop    (pop),
        .dout   (rx_data),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (rx_level)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx; expected bytes and error counts
// come from a queue-based model of frames sent and consumer readiness.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIV   = 50_000_000 / (115200 * 16);
    localparam int unsigned BIT   = DIV * 16;

    logic       clk_50   = 1'b0;
    logic       rst      = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_level;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    int unsigned cyc    = 0;

    uart_rx #(
        .CLK_HZ (50_000_000),
        .BAUD   (115200),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_50     (clk_50),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_level   (rx_level),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // Observed stream, sampled 1 ns after the falling edge.
    byte_t       got_q[$];
    int unsigned valid_cycles = 0;
    int unsigned fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int unsigned rise_cyc = 0;
    logic        prev_valid = 1'b0;

    always begin
        @(negedge clk_50);
        #1;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (parity_err) pe_cnt++;
    end

    // Reference model: bytes expected out, bytes parked in the FIFO, error tallies.
    byte_t       out_q[$];
    byte_t       exp_q[$];
    int unsigned exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int unsigned gp = 0;
    int unsigned edge_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_frame(input byte_t d, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        edge_cyc = cyc;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cycles(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        wait_cycles(BIT);
`endif
        rx = stop_bit;
        wait_cycles(BIT);
        rx = 1'b1;
        if (!stop_bit) exp_fe++;
        else if (par_flip) exp_pe++;
        else if (rx_ready) out_q.push_back(d);
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ov++;
    endtask

    task automatic set_ready(input logic r);
        rx_ready = r;
        if (r) begin
            while (exp_q.size() > 0) out_q.push_back(exp_q.pop_front());
        end
    endtask

    task automatic check_stream(input string tag);
        while (out_q.size() > 0) begin
            byte_t e;
            byte_t o;
            e = out_q.pop_front();
            o = (gp < got_q.size()) ? got_q[gp] : 8'hxx;
            chk(tag, {24'b0, o}, {24'b0, e});
            gp++;
        end
        chk({tag, "_count"}, got_q.size(), gp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, rx_valid}, 0);
        chk({tag, "_data"}, {24'b0, rx_data}, 0);
        chk({tag, "_level"}, {29'b0, rx_level}, 0);
        chk({tag, "_ferr"}, {31'b0, frame_err}, 0);
        chk({tag, "_ovr"}, {31'b0, overrun}, 0);
        chk({tag, "_perr"}, {31'b0, parity_err}, 0);
    endtask

    initial begin
        int unsigned vc0;
        int unsigned lat;
        @(negedge clk_50);
        wait_cycles(5);
        chk_all_zero("reset");
        rst = 1'b0;
        wait_cycles(20);

        // Single frame, latency and one-cycle handshake.
        set_ready(1'b1);
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_cycles(20);
        lat = rise_cyc - edge_cyc;
        chk("a5_latency_window", {31'b0, (lat >= 4104) && (lat <= 4110)}, 1);
        chk("a5_valid_cycles", valid_cycles - vc0, 1);
        check_stream("a5_data");

        // Short start-bit glitch must be rejected silently.
        rx = 1'b0;
        wait_cycles(3 * DIV);
        rx = 1'b1;
        wait_cycles(BIT);
        chk("glitch_valid", {31'b0, rx_valid}, 0);
        chk("glitch_ferr", fe_cnt, exp_fe);
        check_stream("glitch_data");

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cycles(BIT);
        chk("ferr_count", fe_cnt, exp_fe);
        chk("ferr_level", {29'b0, rx_level}, 0);
        check_stream("ferr_data");

        // Fill past capacity, then drain.
        set_ready(1'b0);
        for (int b = 1; b <= 5; b++) send_frame(byte_t'(b), 1'b1, 1'b0);
        wait_cycles(20);
        chk("ovr_level", {29'b0, rx_level}, DEPTH);
        chk("ovr_count", ov_cnt, exp_ov);
        chk("ovr_head", {24'b0, rx_data}, 8'h01);
        set_ready(1'b1);
        wait_cycles(10);
        chk("ovr_drained_level", {29'b0, rx_level}, 0);
        check_stream("ovr_drain");

        // Randomized bytes with random consumer readiness.
        for (int k = 0; k < 3; k++) begin
            set_ready(1'($urandom_range(0, 1)));
            send_frame(byte_t'($urandom), 1'b1, 1'b0);
            wait_cycles(10);
        end
        set_ready(1'b1);
        wait_cycles(10);
        chk("rand_ovr", ov_cnt, exp_ov);
        check_stream("rand_data");

        // Back-to-back frames, no idle gap.
        set_ready(1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        wait_cycles(20);
        chk("b2b_level", {29'b0, rx_level}, 2);
        chk("b2b_head", {24'b0, rx_data}, 8'h55);

        // Reset in the middle of the data bits of 0xFF.
        rx = 1'b0;
        wait_cycles(BIT);
        rx = 1'b1;
        wait_cycles(3 * BIT + BIT / 2);
        rst = 1'b1;
        wait_cycles(2);
        chk_all_zero("midrst");
        wait_cycles(5);
        rst = 1'b0;
        exp_q.delete();
        wait_cycles(6 * BIT);
        set_ready(1'b1);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_cycles(20);
        check_stream("post_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cycles(20);
        check_stream("par_good");
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(20);
        chk("par_err_count", pe_cnt, exp_pe);
        chk("par_ferr_count", fe_cnt, exp_fe);
        check_stream("par_bad");
`else
        chk("perr_tied", pe_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
